// File: rtl/serial_frame_ctrl.sv
// Serial frame receiver: hunts a start pattern, reads a channel+length header,
// then forwards a length-counted payload with per-bit valid strobes.
//
//  state   | meaning
//  --------+-------------------------------------------------------
//  HUNT    | shifting serin, looking for START_PAT
//  HDR     | collecting CH_W+LEN_W header bits, channel first
//  PAYLOAD | forwarding payload bits until remaining count expires
module serial_frame_ctrl #(
    parameter int                 START_W   = 4,
    parameter logic [START_W-1:0] START_PAT = 4'b0110,
    parameter int                 CH_W      = 2,
    parameter int                 LEN_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serin,
    input  logic                 serin_en,
    input  logic                 abort,
    output logic                 out_bit,
    output logic                 out_valid,
    output logic [CH_W-1:0]      out_ch,
    output logic [2**CH_W-1:0]   ch_busy,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int NCH   = 2**CH_W;
    localparam int HDR_W = CH_W + LEN_W;
    localparam int HC_W  = $clog2(HDR_W + 1);

    typedef enum logic [1:0] {HUNT, HDR, PAYLOAD} state_t;

    state_t             state;
    logic [START_W-2:0] sr;
    logic [HDR_W-2:0]   hdr_sr;
    logic [HC_W-1:0]    hdr_cnt;
    logic [LEN_W-1:0]   rem;

    logic [START_W-1:0] sr_next;
    logic [HDR_W-1:0]   hdr_next;
    logic               hdr_last;
    logic [CH_W-1:0]    hdr_ch;
    logic [LEN_W-1:0]   hdr_len;
    logic [NCH-1:0]     hdr_onehot;

    // The bit arriving this cycle takes part in both the start match and the header latch.
    always_comb begin
        sr_next    = {sr, serin};
        hdr_next   = {hdr_sr, serin};
        hdr_last   = (hdr_cnt == HC_W'(HDR_W - 1));
        hdr_ch     = hdr_next[HDR_W-1 -: CH_W];
        hdr_len    = hdr_next[LEN_W-1:0];
        hdr_onehot = NCH'(1) << hdr_ch;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= HUNT;
            sr         <= '0;
            hdr_sr     <= '0;
            hdr_cnt    <= '0;
            rem        <= '0;
            out_bit    <= 1'b0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            ch_busy    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (abort) begin
                if (state != HUNT) begin
                    frame_err <= 1'b1;
                end
                state   <= HUNT;
                busy    <= 1'b0;
                sr      <= '0;
                hdr_cnt <= '0;
                rem     <= '0;
                ch_busy <= '0;
            end else if (serin_en) begin
                case (state)
                    HUNT: begin
                        sr <= sr_next[START_W-2:0];
                        if (sr_next == START_PAT) begin
                            state   <= HDR;
                            busy    <= 1'b1;
                            hdr_cnt <= '0;
                        end
                    end
                    HDR: begin
                        hdr_sr  <= hdr_next[HDR_W-2:0];
                        hdr_cnt <= hdr_cnt + HC_W'(1);
                        if (hdr_last) begin
                            out_ch  <= hdr_ch;
                            hdr_cnt <= '0;
                            if (hdr_len == '0) begin
                                state     <= HUNT;
                                busy      <= 1'b0;
                                frame_err <= 1'b1;
                                sr        <= '0;
                            end else begin
                                state   <= PAYLOAD;
                                rem     <= hdr_len;
                                ch_busy <= hdr_onehot;
                            end
                        end
                    end
                    PAYLOAD: begin
                        out_valid <= 1'b1;
                        out_bit   <= serin;
                        rem       <= rem - LEN_W'(1);
                        // Clearing sr keeps payload bits out of the next start match.
                        if (rem == LEN_W'(1)) begin
                            frame_done <= 1'b1;
                            ch_busy    <= '0;
                            state      <= HUNT;
                            busy       <= 1'b0;
                            sr         <= '0;
                        end
                    end
                    default: begin
                        state <= HUNT;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Bench for serial_frame_ctrl: a vector table of inputs and expected outputs,
// driven one per clock with expectations queued and checked after each edge.
module tb_serial_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serin = 1'b0;
    logic       serin_en = 1'b0;
    logic       abort = 1'b0;
    logic       out_bit;
    logic       out_valid;
    logic [1:0] out_ch;
    logic [3:0] ch_busy;
    logic       frame_done;
    logic       frame_err;
    logic       busy;

    serial_frame_ctrl #(
        .START_W(4), .START_PAT(4'b0110), .CH_W(2), .LEN_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .serin(serin), .serin_en(serin_en), .abort(abort),
        .out_bit(out_bit), .out_valid(out_valid), .out_ch(out_ch), .ch_busy(ch_busy),
        .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // exp packing: {ov, ob, och[1:0], cb[3:0], fd, fe, busy}
    typedef struct {
        int         id;
        logic       rst_n;
        logic       en;
        logic       ser;
        logic       ab;
        logic [10:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [10:0] sb[$];
    int          total = 0;
    int          bad = 0;
    bit          stall_on = 1'b0;
    logic        h_ob = 1'b0;
    logic [1:0]  h_och = 2'd0;

    function automatic void add(int id, logic r, logic e, logic s, logic a,
                                logic ov, logic ob, logic [1:0] och, logic [3:0] cb,
                                logic fd, logic fe, logic bz);
        vec_t v;
        v.id = id; v.rst_n = r; v.en = e; v.ser = s; v.ab = a;
        v.exp = {ov, ob, och, cb, fd, fe, bz};
        vecs.push_back(v);
        // Stalled cycles must not consume the (deliberately inverted) bit or pulse anything.
        if (stall_on && e && r && !a) begin
            for (int k = 0; k < 2; k++) begin
                vec_t w;
                w = v;
                w.en = 1'b0;
                w.ser = ~s;
                w.exp[10] = 1'b0;
                w.exp[2] = 1'b0;
                w.exp[1] = 1'b0;
                vecs.push_back(w);
            end
        end
    endfunction

    // Start pattern 0110, header {ch,len}, then npay payload bits (MSB of pay[npay-1:0] first).
    function automatic void frame(int id, logic [1:0] ch, logic [3:0] len,
                                  logic [15:0] pay, int npay);
        logic [3:0] st;
        logic [5:0] hdr;
        logic [3:0] oh;
        st  = 4'b0110;
        hdr = {ch, len};
        oh  = 4'b0001 << ch;
        for (int k = 0; k < 4; k++)
            add(id, 1, 1, st[3-k], 0, 0, h_ob, h_och, 4'b0, 0, 0, k == 3);
        for (int k = 0; k < 6; k++) begin
            if (k < 5) begin
                add(id, 1, 1, hdr[5-k], 0, 0, h_ob, h_och, 4'b0, 0, 0, 1);
            end else begin
                h_och = ch;
                if (len == 4'd0) add(id, 1, 1, hdr[0], 0, 0, h_ob, h_och, 4'b0, 0, 1, 0);
                else             add(id, 1, 1, hdr[0], 0, 0, h_ob, h_och, oh, 0, 0, 1);
            end
        end
        for (int k = 0; k < npay; k++) begin
            logic b;
            logic last;
            b    = pay[npay-1-k];
            last = (k == int'(len) - 1);
            h_ob = b;
            add(id, 1, 1, b, 0, 1, b, ch, last ? 4'b0 : oh, last, 0, !last);
        end
    endfunction

    initial begin
        // 0: reset values
        add(0, 0, 0, 0, 0, 0, 0, 2'd0, 4'b0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 2'd0, 4'b0, 0, 0, 0);
        // 1: basic ch2 len3 payload 101
        frame(1, 2'd2, 4'd3, 16'b101, 3);
        // 2: same frame with two stall cycles after every bit
        stall_on = 1'b1;
        frame(2, 2'd2, 4'd3, 16'b101, 3);
        stall_on = 1'b0;
        // 3: zero-length header, then ch1 len1
        frame(3, 2'd1, 4'd0, 16'b0, 0);
        frame(3, 2'd1, 4'd1, 16'b0, 1);
        // 4: overlapping prefix 01 + 0110 -> match on sixth bit
        add(4, 1, 1, 0, 0, 0, h_ob, h_och, 4'b0, 0, 0, 0);
        add(4, 1, 1, 1, 0, 0, h_ob, h_och, 4'b0, 0, 0, 0);
        frame(4, 2'd0, 4'd1, 16'b1, 1);
        // 5: abort after 3 of 5 payload bits (abort wins over a stalled enable)
        frame(5, 2'd3, 4'd5, 16'b110, 3);
        add(5, 1, 0, 0, 1, 0, h_ob, h_och, 4'b0, 0, 1, 0);
        frame(5, 2'd1, 4'd1, 16'b1, 1);
        // 7: abort in HUNT clears the partial start match without an error pulse
        add(7, 1, 1, 0, 0, 0, h_ob, h_och, 4'b0, 0, 0, 0);
        add(7, 1, 1, 1, 0, 0, h_ob, h_och, 4'b0, 0, 0, 0);
        add(7, 1, 1, 1, 0, 0, h_ob, h_och, 4'b0, 0, 0, 0);
        add(7, 1, 1, 0, 1, 0, h_ob, h_och, 4'b0, 0, 0, 0);
        frame(7, 2'd3, 4'd2, 16'b01, 2);
        // 6: reset mid-payload, trailing payload bits ignored, then a fresh frame
        frame(6, 2'd2, 4'd4, 16'b10, 2);
        h_ob = 1'b0;
        h_och = 2'd0;
        add(6, 0, 1, 1, 0, 0, 0, 2'd0, 4'b0, 0, 0, 0);
        add(6, 1, 1, 1, 0, 0, 0, 2'd0, 4'b0, 0, 0, 0);
        add(6, 1, 1, 0, 0, 0, 0, 2'd0, 4'b0, 0, 0, 0);
        add(6, 1, 1, 1, 0, 0, 0, 2'd0, 4'b0, 0, 0, 0);
        frame(6, 2'd1, 4'd1, 16'b0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            logic [10:0] got;
            logic [10:0] want;
            rst_n    = vecs[i].rst_n;
            serin_en = vecs[i].en;
            serin    = vecs[i].ser;
            abort    = vecs[i].ab;
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            got  = {out_valid, out_bit, out_ch, ch_busy, frame_done, frame_err, busy};
            want = sb.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL outputs test%0d vec%0d: got {ov,ob,ch,cb,fd,fe,busy}=%b required %b",
                         vecs[i].id, i, got, want);
            end
            total++;
            if (frame_done && frame_err) begin
                bad++;
                $display("FAIL done_err_excl test%0d vec%0d: got fd=%b fe=%b required not both 1",
                         vecs[i].id, i, frame_done, frame_err);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
